// File: rtl/usb_pkt_serializer.sv
// USB packet-body serializer: PID, token fields, payload and CRC5/CRC16 as one
// LSB-first bit stream with valid/ready backpressure.
module usb_pkt_serializer #(
    parameter int  MAX_BYTES = 8,
    localparam int BW        = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [1:0]             pkt_type,
    input  logic [3:0]             pid,
    input  logic [6:0]             addr,
    input  logic [3:0]             endp,
    input  logic [BW-1:0]          num_bytes,
    input  logic [8*MAX_BYTES-1:0] data,
    output logic                   out_bit,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    localparam int DW = 8 * MAX_BYTES;
    localparam int CW = (DW > 16) ? $clog2(DW) : 4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PID     = 3'd1;
    localparam logic [2:0] S_FIELD   = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CRC     = 3'd4;

    localparam logic [1:0] K_HS   = 2'd0;
    localparam logic [1:0] K_TOK  = 2'd1;
    localparam logic [1:0] K_DATA = 2'd2;

    logic [2:0]    state_q,   state_d;
    logic [1:0]    kind_q,    kind_d;
    logic [BW-1:0] nbytes_q,  nbytes_d;
    logic [CW-1:0] bit_q,     bit_d;
    logic [7:0]    pid_sr_q,  pid_sr_d;
    logic [10:0]   fld_sr_q,  fld_sr_d;
    logic [DW-1:0] data_sr_q, data_sr_d;
    logic [4:0]    crc5_q,    crc5_d;
    logic [15:0]   crc16_q,   crc16_d;
    logic          done_q,    done_d;

    logic xfer;
    logic pid_end;
    logic fld_end;
    logic pay_end;
    logic crc_end;

    // Serial CRC updates, data presented LSB first
    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        logic fb;
        fb = b ^ c[4];
        return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    always_comb begin
        busy      = (state_q != S_IDLE);
        out_valid = busy;
        done      = done_q;
        xfer      = out_valid & out_ready;

        pid_end = (bit_q == CW'(7));
        fld_end = (bit_q == CW'(10));
        pay_end = (32'(bit_q) == ((32'(nbytes_q) << 3) - 32'd1));
        crc_end = (bit_q == ((kind_q == K_TOK) ? CW'(4) : CW'(15)));

        // CRC is sent by shifting the remainder out MSB first, complemented
        case (state_q)
            S_PID:     out_bit = pid_sr_q[0];
            S_FIELD:   out_bit = fld_sr_q[0];
            S_PAYLOAD: out_bit = data_sr_q[0];
            S_CRC:     out_bit = (kind_q == K_TOK) ? ~crc5_q[4] : ~crc16_q[15];
            default:   out_bit = 1'b0;
        endcase

        out_last = ((state_q == S_PID) && (kind_q == K_HS) && pid_end) ||
                   ((state_q == S_CRC) && crc_end);
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        nbytes_d  = nbytes_q;
        bit_d     = bit_q;
        pid_sr_d  = pid_sr_q;
        fld_sr_d  = fld_sr_q;
        data_sr_d = data_sr_q;
        crc5_d    = crc5_q;
        crc16_d   = crc16_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (pkt_type)
                        2'd1:    kind_d = K_TOK;
                        2'd2:    kind_d = K_DATA;
                        default: kind_d = K_HS;
                    endcase
                    nbytes_d  = (num_bytes > BW'(MAX_BYTES)) ? BW'(MAX_BYTES) : num_bytes;
                    pid_sr_d  = {~pid, pid};
                    fld_sr_d  = {endp, addr};
                    data_sr_d = data;
                    crc5_d    = '1;
                    crc16_d   = '1;
                    bit_d     = '0;
                    state_d   = S_PID;
                end
            end
            S_PID: begin
                if (xfer) begin
                    pid_sr_d = pid_sr_q >> 1;
                    if (pid_end) begin
                        bit_d = '0;
                        case (kind_q)
                            K_TOK:   state_d = S_FIELD;
                            K_DATA:  state_d = (nbytes_q == '0) ? S_CRC : S_PAYLOAD;
                            default: begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                        endcase
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_FIELD: begin
                if (xfer) begin
                    fld_sr_d = fld_sr_q >> 1;
                    crc5_d   = crc5_step(crc5_q, fld_sr_q[0]);
                    if (fld_end) begin
                        bit_d   = '0;
                        state_d = S_CRC;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    data_sr_d = data_sr_q >> 1;
                    crc16_d   = crc16_step(crc16_q, data_sr_q[0]);
                    if (pay_end) begin
                        bit_d   = '0;
                        state_d = S_CRC;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_CRC: begin
                if (xfer) begin
                    if (kind_q == K_TOK) begin
                        crc5_d = {crc5_q[3:0], 1'b1};
                    end else begin
                        crc16_d = {crc16_q[14:0], 1'b1};
                    end
                    if (crc_end) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            kind_q    <= K_HS;
            nbytes_q  <= '0;
            bit_q     <= '0;
            pid_sr_q  <= '0;
            fld_sr_q  <= '0;
            data_sr_q <= '0;
            crc5_q    <= '1;
            crc16_q   <= '1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            nbytes_q  <= nbytes_d;
            bit_q     <= bit_d;
            pid_sr_q  <= pid_sr_d;
            fld_sr_q  <= fld_sr_d;
            data_sr_q <= data_sr_d;
            crc5_q    <= crc5_d;
            crc16_q   <= crc16_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_usb_pkt_serializer.sv
// Directed bench for usb_pkt_serializer: handshake, token, ZLP, data with stalls,
// clamping, busy-start rejection, back-to-back packets and mid-packet reset.
module tb_usb_pkt_serializer;

    localparam int MAXB = 8;
    localparam int BW   = $clog2(MAXB + 1);

    logic            clock = 1'b0;
    logic            reset_n;
    logic            start;
    logic [1:0]      pkt_type;
    logic [3:0]      pid;
    logic [6:0]      addr;
    logic [3:0]      endp;
    logic [BW-1:0]   num_bytes;
    logic [8*MAXB-1:0] data;
    logic            out_bit;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;
    logic            done;

    usb_pkt_serializer #(.MAX_BYTES(MAXB)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .pkt_type  (pkt_type),
        .pid       (pid),
        .addr      (addr),
        .endp      (endp),
        .num_bytes (num_bytes),
        .data      (data),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    int   pass_cnt = 0;
    int   total    = 0;
    logic got_q[$];
    logic exp_q[$];
    int   last_pos;
    int   first_valid_cyc;
    int   stall_err;
    bit   timed_out;
    logic [127:0] gv;
    logic [127:0] ev;
    logic [127:0] saved;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Reference stream using reflected (right-shifting) CRC registers
    task automatic exp_build(input logic [1:0] t, input logic [3:0] p, input logic [6:0] a,
                             input logic [3:0] e, input int nb, input logic [8*MAXB-1:0] d);
        logic [7:0]  pb;
        logic [10:0] f;
        logic [4:0]  r5;
        logic [15:0] r16;
        logic [8*MAXB-1:0] ds;
        logic b;
        int n;
        exp_q.delete();
        pb = {~p, p};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(pb[0]);
            pb = pb >> 1;
        end
        if (t == 2'd1) begin
            f  = {e, a};
            r5 = 5'h1F;
            for (int i = 0; i < 11; i++) begin
                b = f[0];
                f = f >> 1;
                exp_q.push_back(b);
                r5 = (r5[0] ^ b) ? ((r5 >> 1) ^ 5'h14) : (r5 >> 1);
            end
            for (int i = 0; i < 5; i++) begin
                exp_q.push_back(~r5[0]);
                r5 = r5 >> 1;
            end
        end else if (t == 2'd2) begin
            n   = (nb > MAXB) ? MAXB : nb;
            ds  = d;
            r16 = 16'hFFFF;
            for (int i = 0; i < 8 * n; i++) begin
                b  = ds[0];
                ds = ds >> 1;
                exp_q.push_back(b);
                r16 = (r16[0] ^ b) ? ((r16 >> 1) ^ 16'hA001) : (r16 >> 1);
            end
            for (int i = 0; i < 16; i++) begin
                exp_q.push_back(~r16[0]);
                r16 = r16 >> 1;
            end
        end
    endtask

    task automatic send_start(input logic [1:0] t, input logic [3:0] p, input logic [6:0] a,
                              input logic [3:0] e, input logic [BW-1:0] nb,
                              input logic [8*MAXB-1:0] d);
        pkt_type  = t;
        pid       = p;
        addr      = a;
        endp      = e;
        num_bytes = nb;
        data      = d;
        start     = 1'b1;
        @(posedge clock); #1;
        start     = 1'b0;
    endtask

    task automatic capture(input bit rnd, input int inj_at, input int maxcyc);
        logic prev_stall;
        logic prev_bit;
        logic xfer_last;
        got_q.delete();
        last_pos        = -1;
        first_valid_cyc = -1;
        stall_err       = 0;
        timed_out       = 1'b1;
        prev_stall      = 1'b0;
        prev_bit        = 1'b0;
        for (int c = 0; c < maxcyc; c++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (c == inj_at) begin
                start     = 1'b1;
                pkt_type  = 2'd0;
                pid       = ~pid;
                addr      = '0;
                endp      = '0;
                num_bytes = BW'(1);
                data      = '0;
            end else begin
                start = 1'b0;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = c;
            if (prev_stall && out_bit !== prev_bit) stall_err++;
            prev_stall = out_valid && !out_ready;
            prev_bit   = out_bit;
            xfer_last  = out_valid && out_ready && out_last;
            if (out_valid && out_ready) begin
                got_q.push_back(out_bit);
                if (out_last) last_pos = got_q.size();
            end
            @(posedge clock); #1;
            if (xfer_last) begin
                timed_out = 1'b0;
                break;
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic verify(input string tag);
        gv = '0;
        ev = '0;
        for (int i = 0; i < got_q.size() && i < 128; i++) gv = gv | (128'(got_q[i]) << i);
        for (int i = 0; i < exp_q.size() && i < 128; i++) ev = ev | (128'(exp_q[i]) << i);
        check({tag, "_timeout"}, 128'(timed_out), 128'(0));
        check({tag, "_len"}, 128'(got_q.size()), 128'(exp_q.size()));
        check({tag, "_stream"}, gv, ev);
        check({tag, "_lastpos"}, 128'(last_pos), 128'(exp_q.size()));
        check({tag, "_done"}, 128'({done, busy, out_valid}), 128'(3'b100));
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        pkt_type  = '0;
        pid       = '0;
        addr      = '0;
        endp      = '0;
        num_bytes = '0;
        data      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outs", 128'({out_valid, out_last, busy, done, out_bit}), 128'(0));
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("idle_outs", 128'({out_valid, out_last, busy, done, out_bit}), 128'(0));

        // ACK
        exp_build(2'd0, 4'b0010, '0, '0, 0, '0);
        send_start(2'd0, 4'b0010, '0, '0, '0, '0);
        check("ack_busy", 128'(busy), 128'(1));
        capture(1'b0, -1, 100);
        verify("ack");
        check("ack_byte", 128'(gv[7:0]), 128'(8'hD2));
        check("ack_first", 128'(first_valid_cyc), 128'(0));

        // Token issued in the ACK's done cycle; start pulse mid-packet must be ignored
        exp_build(2'd1, 4'b0001, 7'h15, 4'hE, 0, '0);
        send_start(2'd1, 4'b0001, 7'h15, 4'hE, '0, '0);
        capture(1'b0, 5, 100);
        verify("tok");
        check("tok_gapfree", 128'(first_valid_cyc), 128'(0));
        check("tok_pid", 128'(gv[7:0]), 128'(8'hE1));
        check("tok_field", 128'(gv[18:8]), 128'(11'h715));
        check("tok_crc5", 128'(gv[23:19]), 128'(5'b11101));

        // Zero-length data packet
        @(posedge clock); #1;
        exp_build(2'd2, 4'b0011, '0, '0, 0, '0);
        send_start(2'd2, 4'b0011, '0, '0, '0, '0);
        capture(1'b0, -1, 100);
        verify("zlp");
        check("zlp_bits", 128'(gv[23:0]), 128'(24'h0000C3));

        // Full payload, then same payload under random backpressure
        exp_build(2'd2, 4'b1011, '0, '0, 8, 64'h0706050403020100);
        send_start(2'd2, 4'b1011, '0, '0, BW'(8), 64'h0706050403020100);
        capture(1'b0, -1, 200);
        verify("data8");
        saved = gv;
        send_start(2'd2, 4'b1011, '0, '0, BW'(8), 64'h0706050403020100);
        capture(1'b1, -1, 2000);
        verify("data8_stall");
        check("stall_same", gv, saved);
        check("stall_hold", 128'(stall_err), 128'(0));

        // Oversized length clamps to MAX_BYTES
        exp_build(2'd2, 4'b0011, '0, '0, 9, 64'hDEADBEEF_12345678);
        send_start(2'd2, 4'b0011, '0, '0, BW'(9), 64'hDEADBEEF_12345678);
        capture(1'b0, -1, 200);
        verify("clamp");
        check("clamp_len", 128'(got_q.size()), 128'(88));

        // Reset while bit 12 of a data packet is on the wire
        send_start(2'd2, 4'b0011, '0, '0, BW'(2), 64'h5AFF);
        repeat (12) begin
            @(posedge clock); #1;
        end
        check("pre_rst", 128'({out_valid, busy, out_bit}), 128'(3'b111));
        reset_n = 1'b0;
        #1;
        check("rst_abort", 128'({out_valid, out_last, busy, done, out_bit}), 128'(0));
        @(posedge clock); #1;
        check("rst_nodone", 128'({out_valid, out_last, busy, done, out_bit}), 128'(0));
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("post_rst_idle", 128'({out_valid, busy, done}), 128'(0));
        exp_build(2'd2, 4'b0011, '0, '0, 3, 64'h00C0FFEE);
        send_start(2'd2, 4'b0011, '0, '0, BW'(3), 64'h00C0FFEE);
        capture(1'b0, -1, 200);
        verify("post_rst");
        @(posedge clock); #1;
        check("done_pulse", 128'(done), 128'(0));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
